// File: rtl/mem_responder.sv
// Single-port word memory behind a valid/ready request/response pair.
// One request in flight; the response appears a fixed LATENCY cycles after accept.
module mem_responder #(
  parameter int BUSW    = 32,
  parameter int MINDW   = 12,
  parameter int MWORDS  = 4096,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [MINDW-1:0] req_addr,
  input  logic [BUSW-1:0]  req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [BUSW-1:0]  rsp_rdata,
  output logic             rsp_we
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Every request spends at least one cycle in WAIT, so the counter
  // start value alone sets the distance from accept to rsp_valid.
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t             state_q;
  logic [3:0]         cnt_q;
  logic               we_q;
  logic [MINDW-1:0]   addr_q;
  logic [BUSW-1:0]    wdata_q;
  logic               req_ready_q;
  logic               rsp_valid_q;
  logic               rsp_we_q;
  logic [BUSW-1:0]    rsp_rdata_q;
  logic [BUSW-1:0]    mem_q [MWORDS];

  logic               enter_resp;
  logic               commit;

  assign enter_resp = (state_q == WAIT) && (cnt_q == 4'd0);
  assign commit     = enter_resp && we_q;

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_we    = rsp_we_q;

  // Control FSM with registered handshake outputs and request latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            cnt_q       <= CNT_INIT;
            req_ready_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            rsp_valid_q <= 1'b1;
            rsp_we_q    <= we_q;
            rsp_rdata_q <= we_q ? '0 : mem_q[addr_q];
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // Storage array; a store lands on the edge that raises its response.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

endmodule
